imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the synchronous-read instruction memory (1-cycle read latency).
//  Owns the PC, drives the memory read address, pairs returned data with its PC and a valid.
//  Applies stall, redirect (jump/branch) and address-range fault; feeds IF/ID of the MIPS pipe.
// PARAMETERS
//  RESET_PC       32'h0    first fetch address after leaving IDLE
//  IMEM_LAST_ADDR 32'd128  highest legal word byte-address; legal = aligned and <= this
// PORTS
//  clk            in   1   single clock, all state on posedge
//  rst_n          in   1   synchronous, active-low reset
//  fetch_en       in   1   start fetching; sampled only in IDLE
//  stall_i        in   1   hold current instruction (load-use stall)
//  redirect_i     in   1   take redirect_pc next
//  redirect_pc    in   32  redirect target byte address
//  imem_addr      out  32  memory read address (combinational from state/inputs)
//  imem_rdata     in   32  memory data, = mem[addr issued previous cycle]
//  instr_o        out  32  instruction to decode (= imem_rdata)
//  instr_pc_o     out  32  byte address of instr_o
//  instr_valid_o  out  1   instr_o/instr_pc_o meaningful
//  fault_o        out  1   sticky fetch-address fault
//  fault_pc_o     out  32  offending address
// BEHAVIOUR
//  - States: IDLE, RUN, FAULT. Reset (any state, any cycle) -> IDLE, fetch_pc_q=RESET_PC,
//    valid_q=0, fault_pc_q=0; instr_valid_o=0, fault_o=0, imem_addr=RESET_PC.
//  - IDLE: imem_addr=RESET_PC; fetch_en=1 -> RUN, fetch_pc_q<=RESET_PC, valid_q<=1.
//  - RUN: next = redirect_i ? redirect_pc : stall_i ? fetch_pc_q : fetch_pc_q+4 (mod 2^32).
//    Priority redirect > stall > increment. next legal: imem_addr=next, fetch_pc_q<=next.
//  - Stall re-issues fetch_pc_q, so instr_o/instr_pc_o hold stable while stall_i=1.
//  - Redirect in cycle R: instr in R unaffected; R+1 presents mem[redirect_pc], valid=1.
//    No delay-slot squash here; decode owns that.
//  - next illegal (misaligned or > IMEM_LAST_ADDR) -> FAULT; imem_addr=fetch_pc_q (no illegal
//    access issued); fault_pc_q<=next. Sequential run past last word faults; no wrap to 0.
//  - FAULT: terminal until reset; instr_valid_o=0, fault_o=1, fault_pc_o=fault_pc_q,
//    imem_addr held; fetch_en/stall_i/redirect_i ignored.
//  - instr_valid_o = (state==RUN) & valid_q; instr_pc_o=fetch_pc_q; instr_o=imem_rdata.
//  - fetch_en is ignored outside IDLE; de-asserting it does not stop RUN.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs fetch_cnt_o[31:0] (+1 each cycle instr_valid_o&~stall_i)
//    and stall_cnt_o[31:0] (+1 each RUN cycle with stall_i); both 0 on reset, wrap at 2^32,
//    frozen in FAULT.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  imem_pkg: fetch_state_e {IDLE,RUN,FAULT}, WORD_BYTES=4, addr_legal() function.
//  Sub-module fetch_perf_cnt (two saturating-free 32-bit counters), instantiated only
//  under FETCH_PERF_EN; FSM, PC and legality check stay in imem_fetch_ctrl.
// TESTING
//  1 Reset low 2 cyc, fetch_en=1 at cyc 3 -> cyc 4: pc 0, instr 0x2001000f valid; then 4,8,12.
//  2 stall_i=1 for 3 cyc while pc 8 -> pc 8/0x20030009 held 4 cyc, then pc 12 (0x20040009).
//  3 redirect_i=1, pc 0x20 while instr pc 4, same cycle stall_i=1 -> next cyc pc 0x20,
//    instr 0x20030009.
//  4 Free run to pc 128 (0x00222020) -> next cyc fault_o=1, fault_pc_o=0x84, valid=0;
//    imem_addr stays 128.
//  5 redirect_pc=0x22 -> FAULT, fault_pc_o=0x22; rst_n=0 one cycle -> IDLE, all outputs reset.
//  6 FETCH_PERF_EN: 10 valid fetches + 3 stall cyc -> fetch_cnt_o=10, stall_cnt_o=3.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared fetch FSM states, word size and address legality check
package imem_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Legal fetch address: word aligned and not beyond the last implemented word
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] last_addr);
        return (addr[1:0] == 2'b00) && (addr <= last_addr);
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: free-running 32-bit counters of issued fetches and stall cycles
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    // Both counters wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            fetch_cnt_o <= fetch_cnt_o + {31'b0, fetch_inc};
            stall_cnt_o <= stall_cnt_o + {31'b0, stall_inc};
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencer for a 1-cycle-latency instruction memory; FETCH_PERF_EN adds perf counters
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter logic [31:0] IMEM_LAST_ADDR = 32'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        fault_o,
`ifdef FETCH_PERF_EN
    output logic [31:0] fault_pc_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`else
    output logic [31:0] fault_pc_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fault_pc_q, next_pc;
    logic         valid_q, next_ok;

    assign next_pc = redirect_i ? redirect_pc : stall_i ? fetch_pc_q : fetch_pc_q + WORD_BYTES;
    assign next_ok = addr_legal(next_pc, IMEM_LAST_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: FAULT is terminal until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fetch_en ? RUN : IDLE;
            RUN:     state_d = next_ok ? RUN : FAULT;
            default: state_d = FAULT;
        endcase
    end

    // Outputs: an illegal next address is never presented to the memory
    always_comb begin
        imem_addr     = (state_q == IDLE) ? RESET_PC : (state_q == RUN && next_ok) ? next_pc : fetch_pc_q;
        instr_valid_o = (state_q == RUN) && valid_q;
        fault_o       = (state_q == FAULT);
        instr_o       = imem_rdata;
        instr_pc_o    = fetch_pc_q;
        fault_pc_o    = fault_pc_q;
    end

    // PC tracks the address issued last cycle so it pairs with imem_rdata
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            fault_pc_q <= '0;
            valid_q    <= 1'b0;
        end else if (state_q == IDLE && fetch_en) begin
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b1;
        end else if (state_q == RUN) begin
            if (next_ok) fetch_pc_q <= next_pc;
            else         fault_pc_q <= next_pc;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc   (instr_valid_o && !stall_i),
        .stall_inc   ((state_q == RUN) && stall_i),
        .fetch_cnt_o (fetch_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );
`endif

endmodule
